// File: rtl/tqvp_cattuto_ws2812b_stream_if.sv
// tqvp_cattuto_ws2812b_stream_if: TinyQV byte-peripheral bus bundle for the WS2812B stream driver
//   address     4  register select (master -> slave)
//   data_write  1  one-cycle write strobe (master -> slave)
//   data_in     8  write data (master -> slave)
//   data_out    8  combinational read data (slave -> master)
interface tqvp_cattuto_ws2812b_stream_if;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;
    modport master (output address, data_write, data_in, input data_out);
    modport slave  (input address, data_write, data_in, output data_out);
endinterface

// File: rtl/tqvp_cattuto_ws2812b_stream.sv
// tqvp_cattuto_ws2812b_stream: queued WS2812B/SK6812 strip driver behind the TinyQV byte bus
//   clk      system clock
//   rst_n    synchronous reset, active low
//   bus      slave side of the byte-peripheral bus (address/data_write/data_in/data_out)
//   led_out  serial data to the strip
//   idle     FIFO empty and serializer idle
// Software stages one pixel (G/R/B[/W]) and pushes it as a command
// {latch, blank, rep}; a FIFO decouples the CPU from the wire timing.
module tqvp_cattuto_ws2812b_stream #(
    parameter int FIFO_DEPTH = 4,
    parameter int BPP        = 3,
    parameter int T0H        = 26,
    parameter int T1H        = 51,
    parameter int TBIT       = 80,
    parameter int TRST       = 5120
) (
    input  logic                          clk,
    input  logic                          rst_n,
    tqvp_cattuto_ws2812b_stream_if.slave  bus,
    output logic                          led_out,
    output logic                          idle
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = 8 * BPP;
    localparam int EW = 8 + PW;
    localparam int CW = $clog2(TRST + 1);
    localparam logic [5:0] NBITS = 6'(PW);
    // HIGH is the only state with bit 2 set, so led_out is a bare flop output.
    localparam logic [2:0] S_IDLE  = 3'b000;
    localparam logic [2:0] S_LOAD  = 3'b001;
    localparam logic [2:0] S_LOW   = 3'b010;
    localparam logic [2:0] S_LATCH = 3'b011;
    localparam logic [2:0] S_HIGH  = 3'b100;

    logic [7:0]    g_q, r_q, b_q, w_q;
    logic          ovf;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [5:0]    bit_cnt;
    logic [5:0]    rep_cnt;
    logic          cur_latch;
    logic [PW-1:0] cur_pix, shreg;
    logic [PW-1:0] stage_pix;
    logic [EW-1:0] head;
    logic [CW-1:0] high_last;
    logic          full, empty, push, accept, pop, bit_end, last_bit;

    generate
        if (BPP == 4) begin : g_rgbw
            assign stage_pix = {g_q, r_q, b_q, w_q};
        end else begin : g_rgb
            assign stage_pix = {g_q, r_q, b_q};
        end
    endgenerate

    assign full      = level == (AW+1)'(FIFO_DEPTH);
    assign empty     = level == '0;
    assign push      = bus.data_write && bus.address == 4'h0;
    // Fullness is judged on occupancy before any same-cycle pop.
    assign accept    = push && !full;
    assign head      = mem[rd_ptr];
    assign high_last = shreg[PW-1] ? CW'(T1H - 1) : CW'(T0H - 1);
    assign bit_end   = state == S_LOW && cnt == CW'(TBIT - 1);
    assign last_bit  = bit_end && bit_cnt == 6'd1 && rep_cnt == 6'd0;
    // Pop from IDLE, or at the end of a non-latching pixel so the next one follows after a single LOAD cycle.
    assign pop       = !empty && (state == S_IDLE || (last_bit && !cur_latch));
    assign led_out   = state[2];
    assign idle      = state == S_IDLE && empty;

    always_comb begin
        bus.data_out = bus.address == 4'h0 ? {ovf, 3'b000, !empty, state == S_LATCH, idle, !full} :
                       bus.address == 4'h1 ? g_q :
                       bus.address == 4'h2 ? r_q :
                       bus.address == 4'h3 ? b_q :
                       bus.address == 4'h4 ? (BPP == 4 ? w_q : 8'h00) :
                       bus.address == 4'h5 ? 8'(level) : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            g_q <= '0;
            r_q <= '0;
            b_q <= '0;
            w_q <= '0;
            ovf <= 1'b0;
        end else begin
            g_q <= (bus.data_write && bus.address == 4'h1) ? bus.data_in : g_q;
            r_q <= (bus.data_write && bus.address == 4'h2) ? bus.data_in : r_q;
            b_q <= (bus.data_write && bus.address == 4'h3) ? bus.data_in : b_q;
            w_q <= (BPP == 4 && bus.data_write && bus.address == 4'h4) ? bus.data_in : w_q;
            ovf <= (push && full) ? 1'b1 : (bus.data_write && bus.address == 4'h5) ? 1'b0 : ovf;
        end
    end

    // Entry layout: {latch, blank, rep[5:0], pixel}; the pixel is a snapshot of staging at push time.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= {bus.data_in, stage_pix};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= accept ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            level  <= level + (AW+1)'(accept) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            rep_cnt   <= '0;
            cur_latch <= 1'b0;
            cur_pix   <= '0;
            shreg     <= '0;
        end else begin
            case (state)
                S_IDLE: state <= pop ? S_LOAD : S_IDLE;
                S_LOAD: begin
                    shreg   <= cur_pix;
                    bit_cnt <= NBITS;
                    cnt     <= '0;
                    state   <= S_HIGH;
                end
                S_HIGH: begin
                    cnt   <= cnt + 1'b1;
                    state <= cnt == high_last ? S_LOW : S_HIGH;
                end
                S_LOW: begin
                    if (!bit_end) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                        if (bit_cnt != 6'd1) begin
                            shreg   <= shreg << 1;
                            bit_cnt <= bit_cnt - 1'b1;
                            state   <= S_HIGH;
                        end else if (rep_cnt != 6'd0) begin
                            // Repeats restart the same pixel with no gap between copies.
                            shreg   <= cur_pix;
                            bit_cnt <= NBITS;
                            rep_cnt <= rep_cnt - 1'b1;
                            state   <= S_HIGH;
                        end else begin
                            state <= cur_latch ? S_LATCH : pop ? S_LOAD : S_IDLE;
                        end
                    end
                end
                S_LATCH: begin
                    cnt   <= cnt == CW'(TRST - 1) ? '0 : cnt + 1'b1;
                    state <= cnt == CW'(TRST - 1) ? S_IDLE : S_LATCH;
                end
                default: state <= S_IDLE;
            endcase
            // A pop only happens with rep_cnt already 0, so this never collides with the decrement above.
            if (pop) begin
                cur_latch <= head[EW-1];
                rep_cnt   <= head[EW-3 -: 6];
                cur_pix   <= head[EW-2] ? '0 : head[PW-1:0];
            end
        end
    end
endmodule
